// File: rtl/icap_dma_ctrl_pkg.sv
// Shared widths, FSM encoding and a saturating-increment helper for the
// ICAP DMA controller.
package icap_dma_ctrl_pkg;

    localparam int ICAP_WORD_W = 32;
    localparam int DDR_ADDR_W  = 27;
    localparam int LEN_W       = 20;
    localparam int BEATS_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

    // Cycle counters stick at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with registered read port and occupancy count.
// The read register updates only on pop, so it holds the last popped word.
module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rd_data_reg;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Registered read port, cleared by reset so the output starts at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_reg <= '0;
        end else if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = rd_data_reg;
    assign count    = count_reg;

endmodule

// File: rtl/icap_dma_ctrl.sv
// DDR-to-ICAP DMA: requests bursts from DDR under a FIFO credit limit,
// streams the returned words into the ICAP write port and reports
// ICAP-active and total elapsed cycle counts.
module icap_dma_ctrl
    import icap_dma_ctrl_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int SWAP_BITS  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pgrm_icap,
    input  logic [DDR_ADDR_W-1:0]   i_ddr_strt_addr,
    input  logic [LEN_W-1:0]        i_trans_len,
    output logic                    o_dma_done,
    output logic                    o_busy,
    output logic                    o_rd_req,
    output logic [DDR_ADDR_W-1:0]   o_rd_addr,
    output logic [BEATS_W-1:0]      o_rd_beats,
    input  logic                    i_rd_ack,
    input  logic                    i_rd_valid,
    input  logic [ICAP_WORD_W-1:0]  i_rd_data,
    output logic                    o_icap_csib,
    output logic                    o_icap_rdwrb,
    output logic [ICAP_WORD_W-1:0]  o_icap_data,
    output logic [LEN_W-1:0]        o_icap_clk_cnt,
    output logic [LEN_W-1:0]        o_total_clk_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = ((CNT_W > BEATS_W) ? CNT_W : BEATS_W) + 2;

    dma_state_t             state_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   rd_req_reg;
    logic [DDR_ADDR_W-1:0]  rd_addr_reg;
    logic [BEATS_W-1:0]     rd_beats_reg;
    logic [LEN_W-1:0]       len_reg;
    logic [LEN_W-1:0]       left_reg;
    logic [CNT_W-1:0]       outstanding_reg;
    logic [LEN_W-1:0]       written_reg;
    logic                   csib_reg;
    logic [LEN_W-1:0]       icap_cnt_reg;
    logic [LEN_W-1:0]       total_cnt_reg;

    logic                   push;
    logic                   pop;
    logic                   start_fire;
    logic                   ack_fire;
    logic                   credit_ok;
    logic [BEATS_W-1:0]     beats_now;
    logic [CNT_W-1:0]       fifo_count;
    logic [ICAP_WORD_W-1:0] fifo_rd_data;
    logic [ICAP_WORD_W-1:0] icap_data_w;

    // Stray read data outside a transfer is dropped; drain one word per cycle.
    assign push       = i_rd_valid & busy_reg;
    assign pop        = busy_reg & (fifo_count != '0);
    assign start_fire = (state_reg == ST_IDLE) & i_pgrm_icap;
    assign ack_fire   = rd_req_reg & i_rd_ack;

    // Next burst size is the smaller of the burst limit and what is left to request.
    always_comb begin
        beats_now = BEATS_W'(BURST_LEN);
        if (left_reg < LEN_W'(BURST_LEN)) begin
            beats_now = left_reg[BEATS_W-1:0];
        end
    end

    // Only request when every in-flight and queued word is guaranteed a FIFO slot.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding_reg) + SUM_W'(beats_now))
                       <= SUM_W'(FIFO_DEPTH);

    sync_word_fifo #(
        .WIDTH (ICAP_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push),
        .push_data (i_rd_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count)
    );

    // ICAP expects each byte bit-reversed relative to the DDR image.
    generate
        if (SWAP_BITS != 0) begin : g_swap
            for (genvar gi = 0; gi < ICAP_WORD_W / 8; gi++) begin : g_byte
                for (genvar gj = 0; gj < 8; gj++) begin : g_bit
                    assign icap_data_w[gi*8 + gj] = fifo_rd_data[gi*8 + 7 - gj];
                end
            end
        end else begin : g_pass
            assign icap_data_w = fifo_rd_data;
        end
    endgenerate

    // Transfer sequencing: latch the job, issue credit-limited bursts, wait for drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_req_reg   <= 1'b0;
            rd_addr_reg  <= '0;
            rd_beats_reg <= '0;
            len_reg      <= '0;
            left_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_pgrm_icap) begin
                        busy_reg    <= 1'b1;
                        rd_addr_reg <= i_ddr_strt_addr;
                        len_reg     <= i_trans_len;
                        left_reg    <= i_trans_len;
                        if (i_trans_len == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (!rd_req_reg) begin
                        if (credit_ok) begin
                            rd_req_reg   <= 1'b1;
                            rd_beats_reg <= beats_now;
                        end
                    end else if (i_rd_ack) begin
                        rd_req_reg  <= 1'b0;
                        rd_addr_reg <= rd_addr_reg + DDR_ADDR_W'({rd_beats_reg, 2'b00});
                        left_reg    <= left_reg - LEN_W'(rd_beats_reg);
                        if (left_reg == LEN_W'(rd_beats_reg)) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (written_reg == len_reg) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Data-side bookkeeping: credits in flight, words written, ICAP strobe, cycle counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding_reg <= '0;
            written_reg     <= '0;
            csib_reg        <= 1'b1;
            icap_cnt_reg    <= '0;
            total_cnt_reg   <= '0;
        end else begin
            csib_reg <= ~pop;
            if (start_fire) begin
                outstanding_reg <= '0;
                written_reg     <= '0;
                icap_cnt_reg    <= '0;
                total_cnt_reg   <= LEN_W'(1);
            end else begin
                outstanding_reg <= outstanding_reg
                                   + (ack_fire ? CNT_W'(rd_beats_reg) : CNT_W'(0))
                                   - CNT_W'(push);
                if (pop) begin
                    written_reg <= written_reg + LEN_W'(1);
                end
                if (!csib_reg) begin
                    icap_cnt_reg <= sat_inc(icap_cnt_reg);
                end
                if (busy_reg) begin
                    total_cnt_reg <= sat_inc(total_cnt_reg);
                end
            end
        end
    end

    assign o_dma_done      = done_reg;
    assign o_busy          = busy_reg;
    assign o_rd_req        = rd_req_reg;
    assign o_rd_addr       = rd_addr_reg;
    assign o_rd_beats      = rd_beats_reg;
    assign o_icap_csib     = csib_reg;
    assign o_icap_rdwrb    = 1'b0;
    assign o_icap_data     = icap_data_w;
    assign o_icap_clk_cnt  = icap_cnt_reg;
    assign o_total_clk_cnt = total_cnt_reg;

endmodule

// File: tb/tb_icap_dma_ctrl.sv
// Bench for icap_dma_ctrl: a DDR responder model feeds read data, expected
// ICAP words and burst requests are queued and compared as the DUT produces them.
module tb_icap_dma_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_pgrm_icap;
    logic [26:0] i_ddr_strt_addr;
    logic [19:0] i_trans_len;
    logic        o_dma_done;
    logic        o_busy;
    logic        o_rd_req;
    logic [26:0] o_rd_addr;
    logic [7:0]  o_rd_beats;
    logic        i_rd_ack;
    logic        i_rd_valid;
    logic [31:0] i_rd_data;
    logic        o_icap_csib;
    logic        o_icap_rdwrb;
    logic [31:0] o_icap_data;
    logic [19:0] o_icap_clk_cnt;
    logic [19:0] o_total_clk_cnt;

    icap_dma_ctrl #(.BURST_LEN(16), .FIFO_DEPTH(64), .SWAP_BITS(1)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_pgrm_icap     (i_pgrm_icap),
        .i_ddr_strt_addr (i_ddr_strt_addr),
        .i_trans_len     (i_trans_len),
        .o_dma_done      (o_dma_done),
        .o_busy          (o_busy),
        .o_rd_req        (o_rd_req),
        .o_rd_addr       (o_rd_addr),
        .o_rd_beats      (o_rd_beats),
        .i_rd_ack        (i_rd_ack),
        .i_rd_valid      (i_rd_valid),
        .i_rd_data       (i_rd_data),
        .o_icap_csib     (o_icap_csib),
        .o_icap_rdwrb    (o_icap_rdwrb),
        .o_icap_data     (o_icap_data),
        .o_icap_clk_cnt  (o_icap_clk_cnt),
        .o_total_clk_cnt (o_total_clk_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [26:0] addr;
        logic [7:0]  beats;
    } req_t;

    typedef struct {
        logic [26:0] addr;
        int          len;
        int          ack_dly;
        int          thr;
        logic [31:0] base;
        int          exp_total;   // -1: only require total > len
        bit          chk_first;
        logic [31:0] exp_first;
    } vec_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    req_t        exp_req_q[$];
    logic [31:0] exp_icap_q[$];
    logic [31:0] pend_q[$];
    int          cur_ack_dly, cur_thr, data_idx, thr_cnt, ack_wait;
    logic [31:0] data_base;
    int          done_cnt, icap_words, req_cnt, exp_nreq, ovf_cnt;
    logic [31:0] first_icap;
    vec_t        vecs[4];

    function automatic logic [31:0] swap_bytes_bits(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                r[b*8 + i] = w[b*8 + 7 - i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("  ok %s = %0h", name, act);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive DDR responses.
    task automatic step();
        req_t r;
        @(negedge i_clk);
        if (o_dma_done) done_cnt++;
        if (!o_icap_csib) begin
            icap_words++;
            if (icap_words == 1) first_icap = o_icap_data;
            if (exp_icap_q.size() == 0)
                check("icap_unexpected_word", 1, 0);
            else
                check("icap_data", o_icap_data, exp_icap_q.pop_front());
        end
        i_rd_valid = 1'b0;
        if (pend_q.size() > 0 && (thr_cnt % cur_thr) == 0) begin
            i_rd_valid = 1'b1;
            i_rd_data  = pend_q.pop_front();
            exp_icap_q.push_back(swap_bytes_bits(i_rd_data));
        end
        thr_cnt++;
        if (i_rd_ack) begin
            i_rd_ack = 1'b0;
            ack_wait = 0;
        end else if (o_rd_req) begin
            ack_wait++;
            if (ack_wait >= cur_ack_dly) begin
                i_rd_ack = 1'b1;
                req_cnt++;
                if (exp_req_q.size() == 0) begin
                    check("rd_req_unexpected", 1, 0);
                end else begin
                    r = exp_req_q.pop_front();
                    check("rd_addr", o_rd_addr, r.addr);
                    check("rd_beats", o_rd_beats, r.beats);
                end
                for (int k = 0; k < int'(o_rd_beats); k++) begin
                    pend_q.push_back(data_base + 32'(data_idx));
                    data_idx++;
                end
            end
        end
        if (i_rd_valid && dut.fifo_count >= 7'd64) ovf_cnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_done"},   o_dma_done, 0);
        check({tag, "_busy"},   o_busy, 0);
        check({tag, "_rdreq"},  o_rd_req, 0);
        check({tag, "_rdaddr"}, o_rd_addr, 0);
        check({tag, "_beats"},  o_rd_beats, 0);
        check({tag, "_csib"},   o_icap_csib, 1);
        check({tag, "_rdwrb"},  o_icap_rdwrb, 0);
        check({tag, "_data"},   o_icap_data, 0);
        check({tag, "_icnt"},   o_icap_clk_cnt, 0);
        check({tag, "_tcnt"},   o_total_clk_cnt, 0);
    endtask

    task automatic begin_xfer(input logic [26:0] addr, input int len, input logic [31:0] base,
                              input int ackd, input int thr);
        req_t r;
        done_cnt = 0; icap_words = 0; req_cnt = 0; data_idx = 0; thr_cnt = 0; ack_wait = 0;
        cur_ack_dly = ackd; cur_thr = thr; data_base = base; exp_nreq = 0;
        for (int off = 0; off < len; off += 16) begin
            r.addr  = addr + 27'(off * 4);
            r.beats = 8'((len - off) < 16 ? (len - off) : 16);
            exp_req_q.push_back(r);
            exp_nreq++;
        end
        i_ddr_strt_addr = addr;
        i_trans_len     = 20'(len);
        i_pgrm_icap     = 1'b1;
        step();
        i_pgrm_icap     = 1'b0;
        i_ddr_strt_addr = ~addr;
        i_trans_len     = 20'hABCDE;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) step();
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (4) step();
    endtask

    task automatic finish_checks(input string tag, input int len, input int exp_total);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_words"},    icap_words, len);
        check({tag, "_icnt"},     o_icap_clk_cnt, len);
        check({tag, "_nreq"},     req_cnt, exp_nreq);
        check({tag, "_icapq"},    exp_icap_q.size(), 0);
        check({tag, "_reqq"},     exp_req_q.size(), 0);
        check({tag, "_busy"},     o_busy, 0);
        if (exp_total >= 0)
            check({tag, "_tcnt"}, o_total_clk_cnt, exp_total);
        else
            check({tag, "_tcnt_gt_len"}, o_total_clk_cnt > 20'(len), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{27'h100,     5,  2, 1, 32'd1,        12, 1'b1, 32'h0000_0080};
        vecs[1] = '{27'h0,       40, 1, 1, 32'h1000,     -1, 1'b1, 32'h0000_0800};
        vecs[2] = '{27'h2000,    0,  1, 1, 32'h0,        2,  1'b0, 32'h0};
        vecs[3] = '{27'h7FFFFC0, 20, 3, 4, 32'h0180_0000, -1, 1'b1, 32'h8001_0000};

        i_rst = 1'b1; i_pgrm_icap = 1'b0; i_ddr_strt_addr = '0; i_trans_len = '0;
        i_rd_ack = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0;
        cur_ack_dly = 1; cur_thr = 1; data_idx = 0; thr_cnt = 0; ack_wait = 0; data_base = '0;
        done_cnt = 0; icap_words = 0; req_cnt = 0; exp_nreq = 0; ovf_cnt = 0; first_icap = '0;
        repeat (3) @(negedge i_clk);
        check_reset_vals("rst");
        i_rst = 1'b0;
        step();

        // Table-driven transfers
        for (int v = 0; v < 4; v++) begin
            begin_xfer(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].ack_dly, vecs[v].thr);
            wait_done($sformatf("v%0d", v));
            finish_checks($sformatf("v%0d", v), vecs[v].len, vecs[v].exp_total);
            if (vecs[v].chk_first)
                check($sformatf("v%0d_first_word", v), first_icap, vecs[v].exp_first);
            else
                check($sformatf("v%0d_no_icap", v), icap_words, 0);
            repeat (3) step();
        end

        // Start pulse while busy is ignored
        begin_xfer(27'h300, 10, 32'hA0, 3, 1);
        repeat (4) step();
        check("t4_busy_before_restart", o_busy, 1);
        i_ddr_strt_addr = 27'h5000; i_trans_len = 20'd3; i_pgrm_icap = 1'b1;
        step();
        i_pgrm_icap = 1'b0;
        wait_done("t4");
        repeat (30) step();
        finish_checks("t4", 10, -1);

        // Reset mid-transfer aborts; next transfer runs cleanly
        begin_xfer(27'h400, 8, 32'h55, 2, 2);
        for (int k = 0; k < 1000 && icap_words < 3; k++) step();
        check("t5_reached_3_words", icap_words >= 3, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_vals("t5");
        pend_q.delete(); exp_icap_q.delete(); exp_req_q.delete();
        i_rd_valid = 1'b0; i_rd_ack = 1'b0; ack_wait = 0;
        i_rst = 1'b0;
        repeat (10) step();
        check("t5_no_done_after_abort", done_cnt, 0);
        begin_xfer(27'h800, 4, 32'h77, 1, 1);
        wait_done("t5b");
        finish_checks("t5b", 4, -1);

        check("fifo_overflow_events", ovf_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
